updown_counter: RTL and testbench
=================================

UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX, default 2**WIDTH-1: terminal count; the legal count range is 0..MAX, and MAX SHALL be less than 2**WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clr  input  1  synchronous active-low reset.
REQ-005 en  input  1  count enable; one step per clock while high.
REQ-006 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 din  input  WIDTH  load value.
REQ-009 q  output  WIDTH  registered count value.
REQ-010 tc  output  1  combinational terminal-count flag.
REQ-011 wrap  output  1  registered one-cycle pulse after a wrap or saturation event.

Function
REQ-012 Per-edge priority SHALL be: clr low, then load, then en, then hold.
REQ-013 When load=1, q SHALL take din on the next edge; if din>MAX, q SHALL take MAX instead.
REQ-014 When load=0, en=1 and up=1, q SHALL become q+1; if q==MAX, q SHALL become 0 (wrap).
REQ-015 When load=0, en=1 and up=0, q SHALL become q-1; if q==0, q SHALL become MAX (wrap).
REQ-016 When load=0 and en=0, q SHALL hold.
REQ-017 tc SHALL be 1 iff en=1, load=0, and either (up=1 and q==MAX) or (up=0 and q==0).
REQ-018 wrap SHALL be 1 for exactly the cycle after any edge on which tc was 1, and 0 otherwise.
REQ-019 A direction change SHALL take effect on the same edge, with no dead cycle.
REQ-020 All arithmetic SHALL be WIDTH bits wide and SHALL never produce a value above MAX.
REQ-021 load and en asserted together SHALL perform the load only; tc and wrap SHALL stay 0.

Reset
REQ-022 On an edge with clr=0, q SHALL become 0 and wrap SHALL become 0, regardless of load or en.
REQ-023 With clr=0 held, tc SHALL follow REQ-017 using q=0; it SHALL be 1 when en=1, load=0 and up=0.
REQ-024 A reset in the middle of counting SHALL discard the current count; counting SHALL resume from 0 on the first edge with clr=1.

Configuration
REQ-025 Macro COUNTER_SAT_EN selects saturating mode.
- Defined: at a terminal count, q holds at MAX (counting up) or at 0 (counting down) instead of wrapping; tc and wrap behave as in REQ-017 and REQ-018.
- Undefined: wrap-around behaviour per REQ-014 and REQ-015.

Structure
REQ-026 A shared package counter_pkg SHALL hold:
- the direction constants DIR_UP=1 and DIR_DOWN=0;
- the WIDTH limits;
- a typedef for the count type.
REQ-027 One sub-module, counter_next, SHALL compute the next-count value and tc combinationally; the top level holds only the registers and the load/clamp mux.

Verification (WIDTH=4, MAX=9 unless noted)
REQ-028 Hold clr=0 for 3 clocks with en=1 -> q=0 and wrap=0 throughout; after clr=1, q=1 on the first edge.
REQ-029 Set en=1, up=1 from q=0 for 12 clocks -> q steps 0..9 then 0,1; tc=1 only while q==9; wrap pulses one cycle after each 9->0 step.
REQ-030 Set up=0 from q=2 for 4 clocks -> q goes 1,0,9,8; tc=1 while q==0.
REQ-031 Pulse load with din=13 (above MAX) while en=1 -> q=9, tc=0 in that cycle, no wrap pulse; with din=5 -> q=5.
REQ-032 With COUNTER_SAT_EN defined, count up from q=8 for 3 clocks -> q goes 9,9,9; tc=1 and wrap pulses each cycle after the first.
REQ-033 Default parameters (WIDTH=8): count up from q=255 -> q=0 and wrap=1 on the next cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared direction constants, width limits and count type for updown_counter.
package counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
  typedef logic [WIDTH_MAX-1:0] count_t;
endpackage

// File: rtl/counter_next.sv
// counter_next: combinational next-count and terminal-count flag; COUNTER_SAT_EN selects saturation instead of wrap.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  output logic [WIDTH-1:0] nxt,
  output logic             tc
);
  logic at_max, at_min;
  assign at_max = q == MAX;
  assign at_min = q == '0;
  assign tc = en & ~load & (up == DIR_UP ? at_max : at_min);
`ifdef COUNTER_SAT_EN
  assign nxt = up == DIR_UP ? (at_max ? MAX : q + 1'b1) : (at_min ? '0 : q - 1'b1);
`else
  assign nxt = up == DIR_UP ? (at_max ? '0 : q + 1'b1) : (at_min ? MAX : q - 1'b1);
`endif
endmodule

// File: rtl/updown_counter.sv
// updown_counter: loadable up/down counter over 0..MAX with terminal-count flag and wrap pulse.
// Saturating mode when COUNTER_SAT_EN is defined.
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);
  logic [WIDTH-1:0] cur, nxt, ld;
  // while clr is low, tc is judged as if the count were already 0
  assign cur = clr ? q : '0;
  assign ld = din > MAX ? MAX : din;
  counter_next #(.WIDTH(WIDTH), .MAX(MAX)) u_next (
    .q(cur), .en(en), .up(up), .load(load), .nxt(nxt), .tc(tc)
  );
  always_ff @(posedge clk) begin
    if (!clr) begin
      q <= '0;
      wrap <= 1'b0;
    end else begin
      q <= load ? ld : en ? nxt : q;
      wrap <= tc;
    end
  end
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed and random checks of updown_counter (WIDTH=4, MAX=9) plus a default-width instance.
module tb_updown_counter;
  localparam int MX = 9;
  logic clk = 1'b0;
  logic clr, en, up, load;
  logic [3:0] din, q;
  logic tc, wrap;
  logic c8, e8, u8, l8;
  logic [7:0] d8, q8;
  logic tc8, w8;
  int total = 0, bad = 0;
  int mq = 0, mw = 0;
`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .MAX(4'd9)) dut (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .din(din), .q(q), .tc(tc), .wrap(wrap)
  );
  updown_counter dut8 (
    .clk(clk), .clr(c8), .en(e8), .up(u8), .load(l8), .din(d8), .q(q8), .tc(tc8), .wrap(w8)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c, input logic e, input logic u, input logic l, input int d);
    int qe, etc;
    @(negedge clk);
    clr = c; en = e; up = u; load = l; din = d[3:0];
    #1;
    qe = c ? mq : 0;
    etc = (e && !l && (u ? qe == MX : qe == 0)) ? 1 : 0;
    chk("tc", int'(tc), etc);
    if (!c) begin
      mq = 0; mw = 0;
    end else begin
      mw = etc;
      if (l) mq = d > MX ? MX : d;
      else if (e) begin
        if (SAT) mq = u ? (mq + 1 > MX ? MX : mq + 1) : (mq == 0 ? 0 : mq - 1);
        else mq = u ? (mq + 1) % (MX + 1) : (mq + MX) % (MX + 1);
      end
    end
    @(posedge clk);
    #1;
    chk("q", int'(q), mq);
    chk("wrap", int'(wrap), mw);
  endtask

  initial begin
    clr = 0; en = 1; up = 1; load = 0; din = 0;
    c8 = 0; e8 = 0; u8 = 1; l8 = 0; d8 = 0;
    repeat (3) step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0);
    repeat (12) step(1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 2);
    repeat (4) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 13);
    step(1, 1, 1, 1, 5);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 8);
    repeat (3) step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 7);
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
    @(negedge clk); c8 = 1; l8 = 1; d8 = 8'd255;
    @(posedge clk); #1;
    chk("q8_load", int'(q8), 255);
    @(negedge clk); l8 = 0; e8 = 1; u8 = 1;
    #1;
    chk("tc8", int'(tc8), 1);
    @(posedge clk); #1;
    chk("q8_step", int'(q8), SAT ? 255 : 0);
    chk("wrap8", int'(w8), 1);
    @(negedge clk); e8 = 0;
    @(posedge clk); #1;
    chk("wrap8_clear", int'(w8), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
